// File: rtl/freq_avg_lock.sv
// freq_avg_lock -- windowed frequency averager with lock detection.
//
// Averages the last 2^DEPTH_LOG2 accepted frequency samples in a ring
// buffer and raises `locked` once LOCK_CNT consecutive samples land within
// TOL of the running average. Out-of-range samples are rejected; three in
// a row, or a watchdog expiry with no strobe, flush the window back to IDLE.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous active-low reset
//   freq_in   unsigned frequency word, valid with freq_stb
//   freq_stb  one-cycle sample strobe
//   freq_avg  windowed average (held across flushes)
//   avg_vld   one-cycle pulse, freq_avg updated
//   locked    stable-frequency flag
//   reject    one-cycle pulse, sample outside [FMIN, FMAX]
//   timeout   one-cycle pulse, watchdog flush
//
// Build option: define FREQ_AVG_ROUND_EN to round the average to nearest
// instead of truncating.
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | buffer empty
// FILL  | 1 .. 2^DEPTH_LOG2-1 samples held
// TRACK | buffer full, not locked
// LOCK  | buffer full, locked

module freq_avg_lock #(
  parameter int W          = 16,
  parameter int DEPTH_LOG2 = 2,
  parameter int FMIN       = 4500,
  parameter int FMAX       = 5500,
  parameter int TOL        = 50,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] freq_in,
  input  logic         freq_stb,
  output logic [W-1:0] freq_avg,
  output logic         avg_vld,
  output logic         locked,
  output logic         reject,
  output logic         timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = W + DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int LCW   = $clog2(LOCK_CNT + 1);
  localparam int WDW   = $clog2(TIMEOUT + 1);

  localparam logic [W-1:0]   FMIN_W     = W'(FMIN);
  localparam logic [W-1:0]   FMAX_W     = W'(FMAX);
  localparam logic [W-1:0]   TOL_W      = W'(TOL);
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [LCW-1:0] LOCK_CNT_C = LCW'(LOCK_CNT);
  localparam logic [WDW-1:0] TIMEOUT_C  = WDW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FILL, TRACK, LOCK} state_t;

  state_t                state;
  logic [W-1:0]          ring [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [CW-1:0]         count;
  logic [AW-1:0]         acc;
  logic [LCW-1:0]        lock_cnt;
  logic [1:0]            rej_cnt;
  logic [WDW-1:0]        wd_cnt;

  logic           in_range, accept, bad, full, in_tol;
  logic           wd_expire, rej_flush, flush;
  logic [W-1:0]   old_smp, dev, avg_nxt;
  logic [AW-1:0]  acc_nxt;
  logic [CW-1:0]  count_nxt;
  logic [LCW-1:0] lock_cnt_inc;

  always_comb begin
    in_range     = (freq_in >= FMIN_W) && (freq_in <= FMAX_W);
    accept       = freq_stb && in_range;
    bad          = freq_stb && !in_range;
    full         = (count == DEPTH_C);
    // Until the window is full the slot being written holds nothing real.
    old_smp      = full ? ring[wr_ptr] : '0;
    acc_nxt      = acc + AW'(freq_in) - AW'(old_smp);
    count_nxt    = full ? count : count + 1'b1;
    // Deviation is taken against the average as it stands before this sample.
    dev          = (freq_in >= freq_avg) ? (freq_in - freq_avg) : (freq_avg - freq_in);
    in_tol       = (dev <= TOL_W);
    lock_cnt_inc = lock_cnt + 1'b1;
    // A strobe on the expiry cycle reloads the watchdog instead of flushing.
    wd_expire    = !freq_stb && (wd_cnt == WDW'(1));
    rej_flush    = bad && (rej_cnt == 2'd2);
    flush        = wd_expire || rej_flush;
  end

`ifdef FREQ_AVG_ROUND_EN
  localparam int HALF = (DEPTH_LOG2 > 0) ? (1 << (DEPTH_LOG2 - 1)) : 0;
  logic [AW:0] acc_rnd;
  always_comb begin
    acc_rnd = {1'b0, acc_nxt} + (AW+1)'(HALF);
    avg_nxt = acc_rnd[DEPTH_LOG2 +: W];
  end
`else
  always_comb begin
    avg_nxt = acc_nxt[DEPTH_LOG2 +: W];
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      acc      <= '0;
      lock_cnt <= '0;
      rej_cnt  <= '0;
      wd_cnt   <= '0;
      freq_avg <= '0;
      avg_vld  <= 1'b0;
      locked   <= 1'b0;
      reject   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      reject  <= 1'b0;
      timeout <= 1'b0;

      // Down-counter; zero means idle (after reset or after an expiry).
      if (freq_stb)
        wd_cnt <= TIMEOUT_C;
      else if (wd_cnt != '0)
        wd_cnt <= wd_cnt - 1'b1;

      if (flush) begin
        state    <= IDLE;
        for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        acc      <= '0;
        lock_cnt <= '0;
        rej_cnt  <= '0;
        locked   <= 1'b0;
        timeout  <= wd_expire;
        reject   <= bad;
      end else if (bad) begin
        reject  <= 1'b1;
        rej_cnt <= rej_cnt + 1'b1;
      end else if (accept) begin
        rej_cnt      <= '0;
        ring[wr_ptr] <= freq_in;
        wr_ptr       <= wr_ptr + 1'b1;
        acc          <= acc_nxt;
        count        <= count_nxt;
        if (count_nxt == DEPTH_C) begin
          freq_avg <= avg_nxt;
          avg_vld  <= 1'b1;
        end
        case (state)
          IDLE, FILL: begin
            state <= (count_nxt == DEPTH_C) ? TRACK : FILL;
          end
          TRACK: begin
            if (in_tol) begin
              lock_cnt <= lock_cnt_inc;
              if (lock_cnt_inc == LOCK_CNT_C) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              lock_cnt <= '0;
            end
          end
          LOCK: begin
            if (!in_tol) begin
              state    <= TRACK;
              lock_cnt <= '0;
              locked   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_avg_lock.sv
// Directed testbench for freq_avg_lock. TIMEOUT is shortened so the watchdog
// scenarios fit a short run; all other parameters keep their defaults.
module tb_freq_avg_lock;

  localparam int W  = 16;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] freq_in = '0;
  logic         freq_stb = 1'b0;
  logic [W-1:0] freq_avg;
  logic         avg_vld, locked, reject, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  freq_avg_lock #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .freq_in  (freq_in),
    .freq_stb (freq_stb),
    .freq_avg (freq_avg),
    .avg_vld  (avg_vld),
    .locked   (locked),
    .reject   (reject),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Strobe one sample; returns 1 time unit after the edge that took it.
  task automatic send(input logic [W-1:0] v);
    freq_in  = v;
    freq_stb = 1'b1;
    @(posedge clk);
    #1;
    freq_stb = 1'b0;
  endtask

  task automatic do_reset();
    freq_stb = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic lock_5000();
    for (int i = 0; i < 8; i++) send(16'd5000);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({freq_avg, avg_vld, locked, reject, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got avg=%0d vld=%b lk=%b rej=%b to=%b, want all 0",
               freq_avg, avg_vld, locked, reject, timeout);
    end
    n_tests++;
    if (dut.state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", dut.state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill_lock();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send(16'd5000);
      n_tests++;
      if (avg_vld !== (i >= 4)) begin
        n_fail++;
        $display("FAIL fill_vld[%0d]: got %b want %b", i, avg_vld, (i >= 4));
      end
      if (i >= 4) begin
        n_tests++;
        if (freq_avg !== 16'd5000) begin
          n_fail++;
          $display("FAIL fill_avg[%0d]: got %0d want 5000", i, freq_avg);
        end
      end
      n_tests++;
      if (locked !== (i == 8)) begin
        n_fail++;
        $display("FAIL fill_locked[%0d]: got %b want %b", i, locked, (i == 8));
      end
    end
  endtask

  task automatic test_round();
    logic [W-1:0] smp [4];
    logic [W-1:0] exp_avg;
    smp[0] = 16'd5000; smp[1] = 16'd5000; smp[2] = 16'd5001; smp[3] = 16'd5002;
`ifdef FREQ_AVG_ROUND_EN
    exp_avg = 16'd5001;
`else
    exp_avg = 16'd5000;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) send(smp[i]);
    n_tests++;
    if (avg_vld !== 1'b1 || freq_avg !== exp_avg) begin
      n_fail++;
      $display("FAIL round_avg: got vld=%b avg=%0d want vld=1 avg=%0d", avg_vld, freq_avg, exp_avg);
    end
  endtask

  task automatic test_reject();
    do_reset();
    lock_5000();
    send(16'd6000);
    n_tests++;
    if (reject !== 1'b1 || avg_vld !== 1'b0 || freq_avg !== 16'd5000 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL reject_one: got rej=%b vld=%b avg=%0d lk=%b want 1 0 5000 1",
               reject, avg_vld, freq_avg, locked);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (reject !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_pulse: got %b want 0", reject);
    end
    send(16'd6000);
    send(16'd6000);
    n_tests++;
    if (reject !== 1'b1 || locked !== 1'b0 || dut.state !== 2'd0 || freq_avg !== 16'd5000) begin
      n_fail++;
      $display("FAIL reject_flush: got rej=%b lk=%b st=%0d avg=%0d want 1 0 0 5000",
               reject, locked, dut.state, freq_avg);
    end
    send(16'd5000);
    n_tests++;
    if (dut.state !== 2'd1 || avg_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reject_refill: got st=%0d vld=%b want 1 0", dut.state, avg_vld);
    end
  endtask

  task automatic test_track();
    do_reset();
    lock_5000();
    send(16'd5100);
    n_tests++;
    if (locked !== 1'b0 || dut.state !== 2'd2 || freq_avg !== 16'd5025 || avg_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL track_unlock: got lk=%b st=%0d avg=%0d vld=%b want 0 2 5025 1",
               locked, dut.state, freq_avg, avg_vld);
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    int first = 0;
    do_reset();
    lock_5000();
    for (int i = 1; i <= 2 * TO; i++) begin
      @(posedge clk);
      #1;
      if (timeout) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    n_tests++;
    if (cnt != 1 || first != TO) begin
      n_fail++;
      $display("FAIL timeout_pulse: got count=%0d at=%0d want count=1 at=%0d", cnt, first, TO);
    end
    n_tests++;
    if (locked !== 1'b0 || dut.state !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_flush: got lk=%b st=%0d want 0 0", locked, dut.state);
    end
    for (int i = 1; i <= 3; i++) begin
      send(16'd5000);
      n_tests++;
      if (avg_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_refill[%0d]: got vld=%b want 0", i, avg_vld);
      end
    end
  endtask

  task automatic test_stb_at_expiry();
    int cnt = 0;
    do_reset();
    lock_5000();
    repeat (TO - 1) @(posedge clk);
    #1;
    send(16'd5000);
    n_tests++;
    if (timeout !== 1'b0 || locked !== 1'b1 || avg_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL expiry_stb_wins: got to=%b lk=%b vld=%b want 0 1 1", timeout, locked, avg_vld);
    end
    for (int i = 1; i < TO; i++) begin
      @(posedge clk);
      #1;
      if (timeout) cnt++;
    end
    n_tests++;
    if (cnt != 0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL expiry_reload: got timeouts=%0d lk=%b want 0 1", cnt, locked);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_5000();
    send(16'd5000);
    send(16'd5000);
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({freq_avg, avg_vld, locked, reject, timeout} !== '0 || dut.state !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: got avg=%0d vld=%b lk=%b rej=%b to=%b st=%0d want all 0",
               freq_avg, avg_vld, locked, reject, timeout, dut.state);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(16'd5000);
      n_tests++;
      if (avg_vld !== (i == 4)) begin
        n_fail++;
        $display("FAIL async_refill[%0d]: got vld=%b want %b", i, avg_vld, (i == 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_lock();
    test_round();
    test_reject();
    test_track();
    test_timeout();
    test_stb_at_expiry();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_avg_lock.md
FREQ_AVG_LOCK -- requirements
Module: freq_avg_lock

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- W, 16, frequency word width.
- DEPTH_LOG2, 2, log2 of averaging window (4 samples).
- FMIN, 4500, lowest accepted freq_in (inclusive).
- FMAX, 5500, highest accepted freq_in (inclusive).
- TOL, 50, lock tolerance, |freq_in - freq_avg|.
- LOCK_CNT, 4, consecutive in-tolerance samples needed to lock.
- TIMEOUT, 2000000, clk cycles without freq_stb before flush.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- freq_in  in  W  unsigned frequency measurement from the measurement stage.
- freq_stb  in  1  one-cycle strobe, freq_in valid.
- freq_avg  out  W  windowed average.
- avg_vld  out  1  one-cycle pulse, freq_avg updated.
- locked  out  1  stable-frequency flag.
- reject  out  1  one-cycle pulse, sample out of range.
- timeout  out  1  one-cycle pulse, watchdog flush.

Function
REQ-003 States SHALL be IDLE (buffer empty), FILL (1..2^DEPTH_LOG2-1 samples), TRACK (full, unlocked) and LOCK (full, locked).
REQ-004 On freq_stb with FMIN<=freq_in<=FMAX, the sample SHALL be written to a 2^DEPTH_LOG2-entry ring buffer at wr_ptr, and wr_ptr SHALL wrap modulo depth.
REQ-005 Accumulator width SHALL be W+DEPTH_LOG2, updated as acc + new - overwritten entry, with the overwritten entry taken as 0 while not full.
REQ-006 The sample count SHALL saturate at 2^DEPTH_LOG2; IDLE->FILL on the first accepted sample, FILL->TRACK when the count reaches depth.
REQ-007 Once the buffer is full, freq_avg and avg_vld SHALL update one cycle after each accepted strobe; no avg_vld SHALL be issued in IDLE or FILL.
REQ-008 In TRACK, an accepted sample with |freq_in - freq_avg| <= TOL SHALL increment lock_cnt, and any other accepted sample SHALL clear it; TRACK->LOCK when lock_cnt reaches LOCK_CNT.
REQ-009 In LOCK, an accepted sample with deviation > TOL SHALL move to TRACK, clear lock_cnt and deassert locked on the same edge that updates freq_avg.
REQ-010 Deviation SHALL be computed against the freq_avg register value before the update.
REQ-011 On freq_stb with an out-of-range freq_in, the sample SHALL not be written, reject SHALL pulse one cycle later, and the state SHALL be unchanged.
REQ-012 Three consecutive rejects SHALL flush: buffer, acc, count and lock_cnt cleared, state IDLE, locked=0, freq_avg held.
REQ-013 The watchdog SHALL count cycles since the last freq_stb; on reaching TIMEOUT it SHALL flush as in REQ-012 and pulse timeout once, then hold until the next strobe.
REQ-014 If freq_stb coincides with watchdog expiry, the strobe SHALL win: no flush, and the counter SHALL clear.
REQ-015 freq_stb in consecutive cycles SHALL each be processed, with no back-pressure.

Reset
REQ-016 While rst=0, all state SHALL clear asynchronously: freq_avg=0, avg_vld=0, locked=0, reject=0, timeout=0, state IDLE, buffer, pointers and counters 0.
REQ-017 Reset asserted mid-operation SHALL discard all samples, and operation SHALL resume from IDLE on the first edge after release.

Configuration
REQ-018 With macro FREQ_AVG_ROUND_EN defined, freq_avg SHALL equal (acc + 2^(DEPTH_LOG2-1)) >> DEPTH_LOG2; without it, freq_avg SHALL equal acc >> DEPTH_LOG2 (truncation).

Verification
REQ-019 Bench SHALL cover these directed scenarios (defaults used):
- Reset, then 8 strobes of 5000 -> avg_vld on strobes 4-8, freq_avg=5000, locked=1 one cycle after the 8th.
- Strobes 5000, 5000, 5001, 5002 -> freq_avg=5000 without the macro, 5001 with FREQ_AVG_ROUND_EN.
- Locked at 5000, then one strobe of 6000 -> reject pulse, freq_avg=5000, locked stays 1; three consecutive 6000 -> IDLE, locked=0.
- Locked at 5000, then strobe of 5100 -> locked=0 one cycle later, state TRACK, freq_avg=5025.
- No strobe for TIMEOUT cycles -> single timeout pulse, locked=0, next 3 strobes give no avg_vld.
- rst=0 asynchronously after 2 strobes -> all outputs 0 immediately; 4 strobes after release -> first avg_vld.
